// File: rtl/chain_toggle_sequencer_if.sv
// chain_toggle_sequencer_if: handshake/bus bundle between the sequencer and the prsim boundary.
// Signals:
//   start, abort        run control (master -> slave)
//   resp, resp_known    chain output and its 0/1 validity (master -> slave)
//   stim                chain input (slave -> master)
//   busy, done, fail    run status (slave -> master)
//   fail_code           0 none, 1 timeout, 2 X output, 3 glitch
//   last_latency        cycles from toggle to match of the latest toggle
//   toggle_count        toggles matched in the current run
interface chain_toggle_sequencer_if #(
    parameter int CNT_W = 8,
    parameter int LAT_W = 8
);
    logic             start;
    logic             abort;
    logic             resp;
    logic             resp_known;
    logic             stim;
    logic             busy;
    logic             done;
    logic             fail;
    logic [1:0]       fail_code;
    logic [LAT_W-1:0] last_latency;
    logic [CNT_W-1:0] toggle_count;

    modport master (
        output start, abort, resp, resp_known,
        input  stim, busy, done, fail, fail_code, last_latency, toggle_count
    );

    modport slave (
        input  start, abort, resp, resp_known,
        output stim, busy, done, fail, fail_code, last_latency, toggle_count
    );
endinterface

// File: rtl/chain_toggle_sequencer.sv
// chain_toggle_sequencer: toggles a chain input, checks the returned polarity and measures propagation latency.
// Ports:
//   clk     sole clock, rising edge
//   nreset  asynchronous active-low reset
//   bus     slave side of chain_toggle_sequencer_if (start/abort/resp/resp_known in,
//           stim/busy/done/fail/fail_code/last_latency/toggle_count out)
module chain_toggle_sequencer #(
    parameter int NUM_TOGGLES   = 8,
    parameter int CNT_W         = 8,
    parameter int LAT_W         = 8,
    parameter int TIMEOUT       = 20,
    parameter int X_GRACE       = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int INVERT        = 1
) (
    input logic                      clk,
    input logic                      nreset,
    chain_toggle_sequencer_if.slave  bus
);
    localparam int XW = $clog2(X_GRACE + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SETTLE, DONE, FAIL} state_t;

    state_t           state_q, state_d;
    logic             stim_q, stim_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [1:0]       code_q, code_d;
    logic [LAT_W-1:0] last_q, last_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XW-1:0]    xcnt_q, xcnt_d;
    logic [SW-1:0]    scnt_q, scnt_d;

    logic             expected;
    logic             match;
    logic [LAT_W-1:0] lat_inc;
    logic [CNT_W-1:0] cnt_inc;

    assign expected = stim_q ^ 1'(INVERT);
    assign match    = bus.resp_known && (bus.resp == expected);
    // Latency saturates rather than wrapping so a slow chain never reports a small value.
    assign lat_inc  = (&lat_q) ? lat_q : lat_q + 1'b1;
    assign cnt_inc  = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            stim_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= 2'd0;
            last_q  <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
            xcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            last_q  <= last_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            xcnt_q  <= xcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        done_d  = done_q;
        fail_d  = fail_q;
        code_d  = code_q;
        last_d  = last_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        xcnt_d  = xcnt_q;
        scnt_d  = scnt_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, FAIL: begin
                    if (bus.start) begin
                        done_d  = 1'b0;
                        fail_d  = 1'b0;
                        code_d  = 2'd0;
                        cnt_d   = '0;
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    stim_d  = ~stim_q;
                    lat_d   = '0;
                    xcnt_d  = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (match) begin
                        last_d  = lat_inc;
                        cnt_d   = cnt_inc;
                        scnt_d  = '0;
                        done_d  = (cnt_inc == CNT_W'(NUM_TOGGLES));
                        state_d = (cnt_inc == CNT_W'(NUM_TOGGLES)) ? DONE : SETTLE;
                    end else if (!bus.resp_known) begin
                        // X cycles do not advance the latency count; only xcnt grows.
                        xcnt_d = xcnt_q + 1'b1;
                        if (int'(xcnt_q) + 1 >= X_GRACE) begin
                            fail_d  = 1'b1;
                            code_d  = 2'd2;
                            state_d = FAIL;
                        end
                    end else if (int'(lat_q) + 1 >= TIMEOUT) begin
                        fail_d  = 1'b1;
                        code_d  = 2'd1;
                        state_d = FAIL;
                    end else begin
                        lat_d  = lat_inc;
                        xcnt_d = '0;
                    end
                end
                SETTLE: begin
                    if (!match) begin
                        fail_d  = 1'b1;
                        code_d  = 2'd3;
                        state_d = FAIL;
                    end else begin
                        scnt_d  = scnt_q + 1'b1;
                        state_d = (int'(scnt_q) + 1 >= SETTLE_CYCLES) ? DRIVE : SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.stim         = stim_q;
    assign bus.busy         = (state_q == DRIVE) || (state_q == WAIT) || (state_q == SETTLE);
    assign bus.done         = done_q;
    assign bus.fail         = fail_q;
    assign bus.fail_code    = code_q;
    assign bus.last_latency = last_q;
    assign bus.toggle_count = cnt_q;
endmodule

// File: tb/tb_chain_toggle_sequencer.sv
// tb_chain_toggle_sequencer: self-checking bench with a chain model, a vector table and a per-toggle scoreboard.
module tb_chain_toggle_sequencer;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, abort = 1'b0, known = 1'b1, glitch = 1'b0;
    int   mode = 0;
    logic sstart = 1'b0;

    logic [1:0]   pipe  = '1;
    logic [251:0] pipe2 = '1;
    logic         resp_src;

    chain_toggle_sequencer_if #(.CNT_W(8), .LAT_W(8)) dif ();
    chain_toggle_sequencer_if #(.CNT_W(8), .LAT_W(8)) sif ();

    chain_toggle_sequencer dut (.clk(clk), .nreset(nreset), .bus(dif));
    chain_toggle_sequencer #(.NUM_TOGGLES(2), .TIMEOUT(254)) dut_slow (.clk(clk), .nreset(nreset), .bus(sif));

    // Chain models: mode 0 = inverter with 3-cycle latency, 1 = zero-delay inverter, 2 = stuck at 0.
    always @(posedge clk) pipe  <= {pipe[0], ~dif.stim};
    always @(posedge clk) pipe2 <= {pipe2[250:0], ~sif.stim};
    assign resp_src       = (mode == 0) ? pipe[1] : (mode == 1) ? ~dif.stim : 1'b0;
    assign dif.resp       = glitch ? ~resp_src : resp_src;
    assign dif.resp_known = known;
    assign dif.start      = start;
    assign dif.abort      = abort;
    assign sif.resp       = pipe2[251];
    assign sif.resp_known = 1'b1;
    assign sif.start      = sstart;
    assign sif.abort      = 1'b0;

    typedef struct {
        int mode; bit known; int n_match; int lat;
        bit done; bit fail; int code; int cnt;
    } vec_t;
    typedef struct { int cnt; int lat; } exp_t;

    vec_t vecs[4];
    exp_t sbq[$];
    int   checks = 0, errors = 0, prev_cnt = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every wait goes through tick so each new toggle_count is scored against the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (int'(dif.toggle_count) != prev_cnt) begin
            prev_cnt = int'(dif.toggle_count);
            if (prev_cnt != 0) begin
                if (sbq.size() == 0) chk("sb_unexpected_toggle", prev_cnt, 0);
                else begin
                    e = sbq.pop_front();
                    chk("sb_count", prev_cnt, e.cnt);
                    chk("sb_latency", int'(dif.last_latency), e.lat);
                end
            end
        end
    endtask

    task automatic push(int n, int lat);
        for (int i = 1; i <= n; i++) sbq.push_back('{i, lat});
    endtask

    task automatic do_reset();
        nreset = 1'b0; start = 1'b0; abort = 1'b0; known = 1'b1; glitch = 1'b0;
        repeat (2) tick();
        nreset = 1'b1;
        repeat (10) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(int budget);
        int n = 0;
        while (!(dif.done || dif.fail) && n < budget) begin tick(); n++; end
        chk("run_ended", int'(dif.done || dif.fail), 1);
    endtask

    task automatic wait_cnt(int c);
        int n = 0;
        while (int'(dif.toggle_count) != c && n < 2000) begin tick(); n++; end
        chk("reach_count", int'(dif.toggle_count), c);
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 1'b1, 8, 3, 1'b1, 1'b0, 0, 8};
        vecs[1] = '{1, 1'b1, 8, 1, 1'b1, 1'b0, 0, 8};
        vecs[2] = '{2, 1'b1, 1, 1, 1'b0, 1'b1, 1, 1};
        vecs[3] = '{0, 1'b0, 0, 0, 1'b0, 1'b1, 2, 0};

        do_reset();
        chk("rst_stim", int'(dif.stim), 0);
        chk("rst_busy", int'(dif.busy), 0);
        chk("rst_done", int'(dif.done), 0);
        chk("rst_fail", int'(dif.fail), 0);
        chk("rst_code", int'(dif.fail_code), 0);
        chk("rst_latency", int'(dif.last_latency), 0);
        chk("rst_count", int'(dif.toggle_count), 0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            mode  = vecs[i].mode;
            known = vecs[i].known;
            push(vecs[i].n_match, vecs[i].lat);
            pulse_start();
            chk("vec_busy_running", int'(dif.busy), 1);
            wait_end(2000);
            known = 1'b1;
            chk("vec_done", int'(dif.done), int'(vecs[i].done));
            chk("vec_fail", int'(dif.fail), int'(vecs[i].fail));
            chk("vec_code", int'(dif.fail_code), vecs[i].code);
            chk("vec_count", int'(dif.toggle_count), vecs[i].cnt);
            chk("vec_busy_after", int'(dif.busy), 0);
            if (vecs[i].done) chk("vec_latency", int'(dif.last_latency), vecs[i].lat);
            chk("vec_sb_drained", sbq.size(), 0);
        end

        // Glitch in SETTLE after toggle 2, then a clean rerun.
        do_reset();
        mode = 0;
        push(2, 3);
        pulse_start();
        wait_cnt(2);
        glitch = 1'b1;
        tick();
        glitch = 1'b0;
        chk("glitch_fail", int'(dif.fail), 1);
        chk("glitch_code", int'(dif.fail_code), 3);
        chk("glitch_count", int'(dif.toggle_count), 2);
        repeat (5) tick();
        push(8, 3);
        pulse_start();
        chk("rerun_fail_cleared", int'(dif.fail), 0);
        chk("rerun_code_cleared", int'(dif.fail_code), 0);
        wait_end(2000);
        chk("rerun_done", int'(dif.done), 1);
        chk("rerun_fail", int'(dif.fail), 0);
        chk("rerun_count", int'(dif.toggle_count), 8);
        chk("rerun_sb_drained", sbq.size(), 0);

        // Abort in WAIT of toggle 5: SETTLE, SETTLE, DRIVE, then WAIT.
        do_reset();
        mode = 0;
        push(4, 3);
        pulse_start();
        wait_cnt(4);
        repeat (3) tick();
        chk("abort_busy_before", int'(dif.busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(dif.busy), 0);
        chk("abort_done", int'(dif.done), 0);
        chk("abort_fail", int'(dif.fail), 0);
        chk("abort_count", int'(dif.toggle_count), 4);
        repeat (5) tick();
        chk("abort_stim_held", int'(dif.stim), 1);
        chk("abort_count_held", int'(dif.toggle_count), 4);
        chk("abort_sb_drained", sbq.size(), 0);

        // Asynchronous reset during SETTLE of toggle 1.
        do_reset();
        mode = 0;
        push(1, 3);
        pulse_start();
        wait_cnt(1);
        #1 nreset = 1'b0;
        #1;
        chk("areset_stim", int'(dif.stim), 0);
        chk("areset_busy", int'(dif.busy), 0);
        chk("areset_done", int'(dif.done), 0);
        chk("areset_fail", int'(dif.fail), 0);
        chk("areset_code", int'(dif.fail_code), 0);
        chk("areset_latency", int'(dif.last_latency), 0);
        chk("areset_count", int'(dif.toggle_count), 0);
        tick();
        nreset = 1'b1;
        chk("areset_sb_drained", sbq.size(), 0);

        // Start while busy is ignored; done stays sticky afterwards.
        do_reset();
        mode = 0;
        push(8, 3);
        pulse_start();
        wait_cnt(3);
        pulse_start();
        wait_end(2000);
        chk("busy_start_count", int'(dif.toggle_count), 8);
        chk("busy_start_done", int'(dif.done), 1);
        repeat (5) tick();
        chk("done_sticky", int'(dif.done), 1);
        chk("done_stim_home", int'(dif.stim), 0);
        chk("busy_start_sb_drained", sbq.size(), 0);

        // Slow chain: 252-flop delay gives latency TIMEOUT-1 = 253.
        repeat (260) tick();
        sstart = 1'b1;
        tick();
        sstart = 1'b0;
        n = 0;
        while (!(sif.done || sif.fail) && n < 2000) begin tick(); n++; end
        chk("slow_done", int'(sif.done), 1);
        chk("slow_fail", int'(sif.fail), 0);
        chk("slow_latency", int'(sif.last_latency), 253);
        chk("slow_count", int'(sif.toggle_count), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
